bus_arbiter: RTL and testbench

Two-master, one-slave arbiter sharing the single memory bus between the instruction fetch port (ibus) and the load/store port (dbus). It sits between the core and the memory/bus interconnect. It grants one master at a time, latches the granted request and drives it to the slave. It returns the slave's read data and acknowledge to the owning master, raises per-master stall requests while a master waits, and times out a slave that never responds.

---
 rtl/bus_arbiter_if.sv | 51 +++++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - ibus/dbus master ports and shared memory slave port
interface bus_arbiter_if;
    logic        I_ibus_req;
    logic        I_ibus_we;
    logic [31:0] I_ibus_addr;
    logic [31:0] I_ibus_data;
    logic [3:0]  I_ibus_mask;
    logic        O_ibus_ack;
    logic [31:0] O_ibus_data;
    logic        O_ibus_stallreq;

    logic        I_dbus_req;
    logic        I_dbus_we;
    logic [31:0] I_dbus_addr;
    logic [31:0] I_dbus_data;
    logic [3:0]  I_dbus_mask;
    logic        O_dbus_ack;
    logic [31:0] O_dbus_data;
    logic        O_dbus_stallreq;

    logic        O_mem_req;
    logic        O_mem_we;
    logic [31:0] O_mem_addr;
    logic [31:0] O_mem_data;
    logic [3:0]  O_mem_mask;
    logic        I_mem_ack;
    logic [31:0] I_mem_data;
    logic        O_bus_err;

    // Arbiter side.
    modport master (
        input  I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
        output O_ibus_ack, O_ibus_data, O_ibus_stallreq,
        input  I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
        output O_dbus_ack, O_dbus_data, O_dbus_stallreq,
        output O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
        input  I_mem_ack, I_mem_data,
        output O_bus_err
    );

    // Core and memory side.
    modport slave (
        output I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
        input  O_ibus_ack, O_ibus_data, O_ibus_stallreq,
        output I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
        input  O_dbus_ack, O_dbus_data, O_dbus_stallreq,
        input  O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
        output I_mem_ack, I_mem_data,
        input  O_bus_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (fetch/load-store) arbiter for one memory slave with timeout
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic        last_grant_d;
    logic [7:0]  wait_cnt;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic [3:0]  mem_mask_q;

    logic        grant_i;
    logic        grant_d;
    logic        finish;
    logic        ibus_ack_c;
    logic [31:0] ibus_data_c;
    logic        dbus_ack_c;
    logic [31:0] dbus_data_c;
    logic        bus_err_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        finish      = 1'b0;
        ibus_ack_c  = 1'b0;
        ibus_data_c = 32'h0;
        dbus_ack_c  = 1'b0;
        dbus_data_c = 32'h0;
        bus_err_c   = 1'b0;
        case (state)
            IDLE: begin
                // On a conflict the master that did not win last time goes first.
                if (bus.I_ibus_req && bus.I_dbus_req) begin
                    grant_i = last_grant_d;
                    grant_d = ~last_grant_d;
                end else begin
                    grant_i = bus.I_ibus_req;
                    grant_d = bus.I_dbus_req;
                end
                if (grant_i) begin
                    state_next = BUSY_I;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I: begin
                if (bus.I_mem_ack) begin
                    ibus_ack_c  = 1'b1;
                    ibus_data_c = bus.I_mem_data;
                    finish      = 1'b1;
                    state_next  = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    ibus_ack_c = 1'b1;
                    bus_err_c  = 1'b1;
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.I_mem_ack) begin
                    dbus_ack_c  = 1'b1;
                    dbus_data_c = bus.I_mem_data;
                    finish      = 1'b1;
                    state_next  = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    dbus_ack_c = 1'b1;
                    bus_err_c  = 1'b1;
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The slave-side request is captured once at grant and cleared on completion,
    // so the masters are free to change their inputs while the access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_data_q   <= 32'h0;
            mem_mask_q   <= 4'h0;
            wait_cnt     <= 8'h0;
            last_grant_d <= 1'b0;
        end else if (grant_i) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= bus.I_ibus_we;
            mem_addr_q   <= bus.I_ibus_addr;
            mem_data_q   <= bus.I_ibus_data;
            mem_mask_q   <= bus.I_ibus_mask;
            wait_cnt     <= 8'h0;
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= bus.I_dbus_we;
            mem_addr_q   <= bus.I_dbus_addr;
            mem_data_q   <= bus.I_dbus_data;
            mem_mask_q   <= bus.I_dbus_mask;
            wait_cnt     <= 8'h0;
            last_grant_d <= 1'b1;
        end else if (finish) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'h0;
            mem_data_q <= 32'h0;
            mem_mask_q <= 4'h0;
            wait_cnt   <= 8'h0;
        end else if (state != IDLE && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign bus.O_mem_req  = mem_req_q;
    assign bus.O_mem_we   = mem_we_q;
    assign bus.O_mem_addr = mem_addr_q;
    assign bus.O_mem_data = mem_data_q;
    assign bus.O_mem_mask = mem_mask_q;

    assign bus.O_ibus_ack      = ibus_ack_c;
    assign bus.O_ibus_data     = ibus_data_c;
    assign bus.O_ibus_stallreq = bus.I_ibus_req & ~ibus_ack_c;
    assign bus.O_dbus_ack      = dbus_ack_c;
    assign bus.O_dbus_data     = dbus_data_c;
    assign bus.O_dbus_stallreq = bus.I_dbus_req & ~dbus_ack_c;
    assign bus.O_bus_err       = bus_err_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bus_arbiter_if bi ();
    bus_arbiter_if bt ();

    bus_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    bus_arbiter #(.TIMEOUT(4)) u_dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bi.I_ibus_req = 0; bi.I_ibus_we = 0; bi.I_ibus_addr = 0; bi.I_ibus_data = 0; bi.I_ibus_mask = 0;
        bi.I_dbus_req = 0; bi.I_dbus_we = 0; bi.I_dbus_addr = 0; bi.I_dbus_data = 0; bi.I_dbus_mask = 0;
        bi.I_mem_ack = 0; bi.I_mem_data = 0;
        bt.I_ibus_req = 0; bt.I_ibus_we = 0; bt.I_ibus_addr = 0; bt.I_ibus_data = 0; bt.I_ibus_mask = 0;
        bt.I_dbus_req = 0; bt.I_dbus_we = 0; bt.I_dbus_addr = 0; bt.I_dbus_data = 0; bt.I_dbus_mask = 0;
        bt.I_mem_ack = 0; bt.I_mem_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h want 0", bi.O_mem_req); end
        n_checks++; if (bi.O_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0h want 0", bi.O_mem_we); end
        n_checks++; if (bi.O_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bi.O_mem_addr); end
        n_checks++; if (bi.O_mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h want 0", bi.O_mem_data); end
        n_checks++; if (bi.O_mem_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mem_mask: got %h want 0", bi.O_mem_mask); end
        n_checks++; if ({bi.O_ibus_ack, bi.O_dbus_ack, bi.O_ibus_stallreq, bi.O_dbus_stallreq, bi.O_bus_err} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 00000",
                {bi.O_ibus_ack, bi.O_dbus_ack, bi.O_ibus_stallreq, bi.O_dbus_stallreq, bi.O_bus_err}); end
        n_checks++; if (bt.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_t_mem_req: got %0h want 0", bt.O_mem_req); end
        #1 rst = 0;
        tick();
        @(negedge clk);
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_mem_req: got %0h want 0", bi.O_mem_req); end
        tick();
    endtask

    task automatic test_single_fetch();
        do_reset();
        bi.I_ibus_req = 1; bi.I_ibus_addr = 32'h8000_0000;
        @(negedge clk);
        n_checks++; if (bi.O_ibus_stallreq !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c1: got %0h want 1", bi.O_ibus_stallreq); end
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_req_c1: got %0h want 0", bi.O_mem_req); end
        tick();
        bi.I_mem_ack = 1; bi.I_mem_data = 32'h0000_0013;
        @(negedge clk);
        n_checks++; if (bi.O_mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req_c2: got %0h want 1", bi.O_mem_req); end
        n_checks++; if (bi.O_mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want 80000000", bi.O_mem_addr); end
        n_checks++; if (bi.O_ibus_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack: got %0h want 1", bi.O_ibus_ack); end
        n_checks++; if (bi.O_ibus_data !== 32'h13) begin n_fail++; $display("FAIL fetch_data: got %h want 13", bi.O_ibus_data); end
        n_checks++; if (bi.O_ibus_stallreq !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c2: got %0h want 0", bi.O_ibus_stallreq); end
        n_checks++; if (bi.O_dbus_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_dbus_ack: got %0h want 0", bi.O_dbus_ack); end
        tick();
        bi.I_ibus_req = 0; bi.I_mem_ack = 0;
        @(negedge clk);
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_req_c3: got %0h want 0", bi.O_mem_req); end
        n_checks++; if (bi.O_mem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_idle_addr: got %h want 0", bi.O_mem_addr); end
        n_checks++; if (bi.O_ibus_data !== 32'h0) begin n_fail++; $display("FAIL fetch_idle_data: got %h want 0", bi.O_ibus_data); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bi.I_ibus_req = 1; bi.I_ibus_addr = 32'h100;
        bi.I_dbus_req = 1; bi.I_dbus_addr = 32'h200;
        tick();
        bi.I_mem_ack = 1; bi.I_mem_data = 32'hAA;
        @(negedge clk);
        n_checks++; if (bi.O_mem_addr !== 32'h200) begin n_fail++; $display("FAIL sim_first_addr: got %h want 200", bi.O_mem_addr); end
        n_checks++; if (bi.O_dbus_ack !== 1'b1) begin n_fail++; $display("FAIL sim_dbus_ack: got %0h want 1", bi.O_dbus_ack); end
        n_checks++; if (bi.O_dbus_data !== 32'hAA) begin n_fail++; $display("FAIL sim_dbus_data: got %h want aa", bi.O_dbus_data); end
        n_checks++; if (bi.O_ibus_ack !== 1'b0) begin n_fail++; $display("FAIL sim_ibus_noack: got %0h want 0", bi.O_ibus_ack); end
        n_checks++; if (bi.O_ibus_data !== 32'h0) begin n_fail++; $display("FAIL sim_ibus_nodata: got %h want 0", bi.O_ibus_data); end
        n_checks++; if (bi.O_ibus_stallreq !== 1'b1) begin n_fail++; $display("FAIL sim_ibus_stall_c2: got %0h want 1", bi.O_ibus_stallreq); end
        tick();
        bi.I_dbus_req = 0; bi.I_mem_ack = 0;
        @(negedge clk);
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL sim_idle_gap: got %0h want 0", bi.O_mem_req); end
        n_checks++; if (bi.O_ibus_stallreq !== 1'b1) begin n_fail++; $display("FAIL sim_ibus_stall_c3: got %0h want 1", bi.O_ibus_stallreq); end
        tick();
        bi.I_mem_ack = 1; bi.I_mem_data = 32'hBB;
        @(negedge clk);
        n_checks++; if (bi.O_mem_addr !== 32'h100) begin n_fail++; $display("FAIL sim_second_addr: got %h want 100", bi.O_mem_addr); end
        n_checks++; if (bi.O_ibus_ack !== 1'b1) begin n_fail++; $display("FAIL sim_ibus_ack: got %0h want 1", bi.O_ibus_ack); end
        n_checks++; if (bi.O_ibus_data !== 32'hBB) begin n_fail++; $display("FAIL sim_ibus_data: got %h want bb", bi.O_ibus_data); end
        n_checks++; if (bi.O_dbus_ack !== 1'b0) begin n_fail++; $display("FAIL sim_dbus_noack: got %0h want 0", bi.O_dbus_ack); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_fairness();
        int   slv_cnt;
        int   ack_cyc[$];
        logic ack_who[$];
        int   exp_cyc[4];
        logic exp_who[4];
        exp_cyc = '{4, 8, 12, 16};
        exp_who = '{1'b1, 1'b0, 1'b1, 1'b0};
        slv_cnt = 0;
        do_reset();
        bi.I_ibus_req = 1; bi.I_ibus_addr = 32'h1111;
        bi.I_dbus_req = 1; bi.I_dbus_addr = 32'h2222;
        for (int c = 1; c <= 17; c++) begin
            if (bi.O_mem_req) begin
                if (slv_cnt == 2) begin bi.I_mem_ack = 1; slv_cnt = 0; end
                else begin bi.I_mem_ack = 0; slv_cnt++; end
            end else begin
                bi.I_mem_ack = 0; slv_cnt = 0;
            end
            bi.I_mem_data = 32'hF000_0000 | c;
            @(negedge clk);
            if (bi.O_dbus_ack) begin
                ack_cyc.push_back(c); ack_who.push_back(1'b1);
                n_checks++; if (bi.O_dbus_data !== (32'hF000_0000 | c)) begin n_fail++;
                    $display("FAIL fair_dbus_data: got %h want %h", bi.O_dbus_data, 32'hF000_0000 | c); end
            end
            if (bi.O_ibus_ack) begin
                ack_cyc.push_back(c); ack_who.push_back(1'b0);
                n_checks++; if (bi.O_ibus_data !== (32'hF000_0000 | c)) begin n_fail++;
                    $display("FAIL fair_ibus_data: got %h want %h", bi.O_ibus_data, 32'hF000_0000 | c); end
            end
            tick();
        end
        n_checks++;
        if (ack_cyc.size() != 4) begin
            n_fail++; $display("FAIL fair_ack_count: got %0d want 4", ack_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (ack_cyc[i] != exp_cyc[i]) begin n_fail++;
                    $display("FAIL fair_ack_cycle[%0d]: got %0d want %0d", i, ack_cyc[i], exp_cyc[i]); end
                n_checks++; if (ack_who[i] !== exp_who[i]) begin n_fail++;
                    $display("FAIL fair_ack_owner[%0d]: got %0d want %0d (1=dbus)", i, ack_who[i], exp_who[i]); end
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write_hold();
        do_reset();
        bi.I_dbus_req = 1; bi.I_dbus_we = 1; bi.I_dbus_addr = 32'h1000;
        bi.I_dbus_data = 32'hDEAD_BEEF; bi.I_dbus_mask = 4'b0011;
        tick();
        for (int c = 2; c <= 6; c++) begin
            if (c == 2) begin
                bi.I_dbus_addr = 32'h2000; bi.I_dbus_data = 32'h1234_5678; bi.I_dbus_mask = 4'b1111;
            end
            bi.I_mem_ack = (c == 6); bi.I_mem_data = 32'h77;
            @(negedge clk);
            n_checks++; if ({bi.O_mem_req, bi.O_mem_we} !== 2'b11) begin n_fail++;
                $display("FAIL wr_req_we c%0d: got %b want 11", c, {bi.O_mem_req, bi.O_mem_we}); end
            n_checks++; if (bi.O_mem_addr !== 32'h1000) begin n_fail++;
                $display("FAIL wr_addr c%0d: got %h want 1000", c, bi.O_mem_addr); end
            n_checks++; if (bi.O_mem_data !== 32'hDEAD_BEEF) begin n_fail++;
                $display("FAIL wr_data c%0d: got %h want deadbeef", c, bi.O_mem_data); end
            n_checks++; if (bi.O_mem_mask !== 4'b0011) begin n_fail++;
                $display("FAIL wr_mask c%0d: got %b want 0011", c, bi.O_mem_mask); end
            n_checks++; if (bi.O_dbus_ack !== (c == 6)) begin n_fail++;
                $display("FAIL wr_ack c%0d: got %0h want %0h", c, bi.O_dbus_ack, (c == 6)); end
            n_checks++; if (bi.O_dbus_stallreq !== (c != 6)) begin n_fail++;
                $display("FAIL wr_stall c%0d: got %0h want %0h", c, bi.O_dbus_stallreq, (c != 6)); end
            tick();
        end
        bi.I_dbus_req = 0; bi.I_mem_ack = 0;
        @(negedge clk);
        n_checks++; if ({bi.O_mem_req, bi.O_mem_we, bi.O_mem_mask} !== 6'b0) begin n_fail++;
            $display("FAIL wr_idle: got %b want 000000", {bi.O_mem_req, bi.O_mem_we, bi.O_mem_mask}); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bt.I_ibus_req = 1; bt.I_ibus_addr = 32'h40;
        tick();
        for (int c = 2; c <= 5; c++) begin
            bt.I_mem_data = 32'h55;
            @(negedge clk);
            n_checks++; if (bt.O_ibus_ack !== (c == 5)) begin n_fail++;
                $display("FAIL to_ack c%0d: got %0h want %0h", c, bt.O_ibus_ack, (c == 5)); end
            n_checks++; if (bt.O_bus_err !== (c == 5)) begin n_fail++;
                $display("FAIL to_err c%0d: got %0h want %0h", c, bt.O_bus_err, (c == 5)); end
            n_checks++; if (bt.O_ibus_data !== 32'h0) begin n_fail++;
                $display("FAIL to_data c%0d: got %h want 0", c, bt.O_ibus_data); end
            tick();
        end
        bt.I_ibus_req = 0; bt.I_mem_ack = 1; bt.I_mem_data = 32'h66;
        @(negedge clk);
        n_checks++; if ({bt.O_ibus_ack, bt.O_dbus_ack, bt.O_bus_err, bt.O_mem_req} !== 4'b0) begin n_fail++;
            $display("FAIL to_late_ack: got %b want 0000", {bt.O_ibus_ack, bt.O_dbus_ack, bt.O_bus_err, bt.O_mem_req}); end
        tick();
        bt.I_mem_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        bi.I_dbus_req = 1; bi.I_dbus_addr = 32'h3000;
        tick();
        bi.I_ibus_req = 1; bi.I_ibus_addr = 32'h4000;
        @(negedge clk);
        n_checks++; if (bi.O_mem_addr !== 32'h3000) begin n_fail++; $display("FAIL rm_busy_addr: got %h want 3000", bi.O_mem_addr); end
        #1;
        bi.I_mem_ack = 1; bi.I_mem_data = 32'h88;
        rst = 1;
        #1;
        n_checks++; if (bi.O_mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_mem_req_async: got %0h want 0", bi.O_mem_req); end
        n_checks++; if ({bi.O_dbus_ack, bi.O_ibus_ack} !== 2'b00) begin n_fail++;
            $display("FAIL rm_no_ack: got %b want 00", {bi.O_dbus_ack, bi.O_ibus_ack}); end
        tick();
        bi.I_dbus_req = 0; bi.I_mem_ack = 0;
        rst = 0;
        @(negedge clk);
        n_checks++; if (bi.O_ibus_stallreq !== 1'b1) begin n_fail++; $display("FAIL rm_ibus_wait: got %0h want 1", bi.O_ibus_stallreq); end
        tick();
        bi.I_mem_ack = 1; bi.I_mem_data = 32'h99;
        @(negedge clk);
        n_checks++; if (bi.O_mem_addr !== 32'h4000) begin n_fail++; $display("FAIL rm_ibus_grant: got %h want 4000", bi.O_mem_addr); end
        n_checks++; if (bi.O_ibus_ack !== 1'b1) begin n_fail++; $display("FAIL rm_ibus_ack: got %0h want 1", bi.O_ibus_ack); end
        n_checks++; if (bi.O_ibus_data !== 32'h99) begin n_fail++; $display("FAIL rm_ibus_data: got %h want 99", bi.O_ibus_data); end
        n_checks++; if (bi.O_dbus_ack !== 1'b0) begin n_fail++; $display("FAIL rm_dbus_ack: got %0h want 0", bi.O_dbus_ack); end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_fairness();
        test_write_hold();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
